// File: rtl/top_fetch.sv
// top_fetch: instruction fetch stage.
// Owns the fetch PC and keeps at most one read outstanding to instruction
// memory. Returned words go into a registered output slot for decode, or into
// a one-entry skid register when decode is stalled. Redirects from execute
// flush the slot and skid. A response that is still owed after a redirect is
// drained and dropped.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     read request (addr is fetch_pc, always word-aligned)
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid/rdata one-cycle read data return
//   stall             decode cannot consume the output slot this cycle
//   redirect_valid/pc taken branch/jump from execute
//   instr/pc/pc_plus4 registered output slot (instr = NOP_INSTR when invalid)
//   instr_valid       output slot holds a live instruction
module top_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  instr_valid
);

  localparam logic [DATA_WIDTH-1:0] FOUR       = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [DATA_WIDTH-1:0] skid_instr, skid_pc;

  logic handshake, slot_consume, slot_free;
  logic slot_load, skid_load, skid_to_slot;

  assign imem_addr    = fetch_pc;
  assign handshake    = imem_req && imem_ready;
  assign slot_consume = instr_valid && !stall;
  assign slot_free    = !instr_valid || !stall;

  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    slot_load    = 1'b0;
    skid_load    = 1'b0;
    skid_to_slot = 1'b0;

    case (state)
      S_REQ:   if (handshake) state_n = S_WAIT;
      S_WAIT:  if (imem_rvalid) begin
                 fetch_pc_n = fetch_pc + FOUR;
                 if (slot_free) begin
                   slot_load = 1'b1;
                   state_n   = S_REQ;
                 end else begin
                   skid_load = 1'b1;
                   state_n   = S_HOLD;
                 end
               end
      S_HOLD:  if (slot_free) begin
                 skid_to_slot = 1'b1;
                 state_n      = S_REQ;
               end
      S_DRAIN: if (imem_rvalid) state_n = S_REQ;
      default: state_n = S_REQ;
    endcase

    // Redirect overrides the normal transitions. DRAIN is entered whenever a
    // response is still owed after this edge, so it can be swallowed later.
    if (redirect_valid) begin
      slot_load    = 1'b0;
      skid_load    = 1'b0;
      skid_to_slot = 1'b0;
      fetch_pc_n   = redirect_pc & ALIGN_MASK;
      case (state)
        S_REQ:   state_n = handshake   ? S_DRAIN : S_REQ;
        S_WAIT:  state_n = imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN: state_n = imem_rvalid ? S_REQ   : S_DRAIN;
        default: state_n = S_REQ;
      endcase
    end
  end

  // imem_req is registered from the next state so it is low throughout reset
  // and rises on the first clock edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      imem_req    <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      instr       <= NOP_INSTR;
      pc          <= '0;
      pc_plus4    <= FOUR;
      instr_valid <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      imem_req <= (state_n == S_REQ);

      if (skid_load) begin
        skid_instr <= imem_rdata;
        skid_pc    <= fetch_pc;
      end

      if (redirect_valid) begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
      end else if (slot_load) begin
        instr       <= imem_rdata;
        pc          <= fetch_pc;
        pc_plus4    <= fetch_pc + FOUR;
        instr_valid <= 1'b1;
      end else if (skid_to_slot) begin
        instr       <= skid_instr;
        pc          <= skid_pc;
        pc_plus4    <= skid_pc + FOUR;
        instr_valid <= 1'b1;
      end else if (slot_consume) begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
      end
    end
  end

endmodule
